// File: rtl/game_pkg.sv
// Shared constants and types for the whack-a-mole datapath:
// lamp state encoding, default timing and score register index.
package game_pkg;

  typedef enum logic {
    LIT  = 1'b0,
    DARK = 1'b1
  } lamp_state_e;

  localparam int ON_CYCLES       = 100000000;
  localparam int OFF_CYCLES      = 50000000;
  localparam int DEBOUNCE_CYCLES = 1000000;
  localparam int CNT_W           = 27;
  localparam int PTS_W           = 3;

  localparam logic [4:0] SCORE_REG = 5'd30;

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: two-flop synchronizer, stability counter and a one-cycle
// pulse on each accepted press (debounced level falling 1 -> 0).
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = game_pkg::DEBOUNCE_CYCLES,
  parameter int CNT_W           = game_pkg::CNT_W
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n,
  output logic level,
  output logic press
);

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // The counter only survives while the synced level keeps disagreeing.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    press_d = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == DEB_LAST) begin
        level_d = ~level_q;
        press_d = level_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= btn_n;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/mole_hit_detector.sv
// Whack-a-mole front end: lamp on/off timing, hit qualification while lit and a
// saturating point accumulator offered to the score writer via valid/ready.
module mole_hit_detector #(
  parameter int ON_CYCLES       = game_pkg::ON_CYCLES,
  parameter int OFF_CYCLES      = game_pkg::OFF_CYCLES,
  parameter int DEBOUNCE_CYCLES = game_pkg::DEBOUNCE_CYCLES,
  parameter int CNT_W           = game_pkg::CNT_W,
  parameter int PTS_W           = game_pkg::PTS_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_n,
  output logic             lamp,
  output logic             hit_valid,
  output logic [PTS_W-1:0] hit_pts,
  input  logic             hit_ready,
  output logic             miss,
  output logic [15:0]      hit_total
);
  import game_pkg::*;

  localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(OFF_CYCLES - 1);
  localparam logic [PTS_W-1:0] PTS_MAX  = {PTS_W{1'b1}};

  lamp_state_e      state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic             lamp_q, lamp_d;
  logic             miss_q, miss_d;
  logic [PTS_W-1:0] pending_q, pending_d;
  logic [15:0]      total_q, total_d;
  logic             press, btn_level, hit_evt;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_debounce (
    .clk  (clk),
    .reset(reset),
    .btn_n(btn_n),
    .level(btn_level),
    .press(press)
  );

  // A press in the lit window wins over a simultaneous timeout.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q + 1'b1;
    miss_d    = 1'b0;
    hit_evt   = 1'b0;
    case (state_q)
      LIT: begin
        if (press) begin
          state_d = DARK;
          timer_d = '0;
          hit_evt = 1'b1;
        end else if (timer_q == ON_LAST) begin
          state_d = DARK;
          timer_d = '0;
          miss_d  = 1'b1;
        end
      end
      DARK: begin
        if (timer_q == OFF_LAST) begin
          state_d = LIT;
          timer_d = '0;
        end
      end
      default: begin
        state_d = LIT;
        timer_d = '0;
      end
    endcase
    lamp_d = (state_d == LIT);

    // An accept that coincides with a hit restarts the count at 1 so no point is lost.
    pending_d = pending_q;
    if (hit_valid && hit_ready) begin
      pending_d = hit_evt ? PTS_W'(1) : '0;
    end else if (hit_evt && pending_q != PTS_MAX) begin
      pending_d = pending_q + 1'b1;
    end
    total_d = hit_evt ? total_q + 16'd1 : total_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= LIT;
      timer_q   <= '0;
      lamp_q    <= 1'b1;
      miss_q    <= 1'b0;
      pending_q <= '0;
      total_q   <= '0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      lamp_q    <= lamp_d;
      miss_q    <= miss_d;
      pending_q <= pending_d;
      total_q   <= total_d;
    end
  end

  always_ff @(posedge clk) begin
    assert (ON_CYCLES > 0 && OFF_CYCLES > 0 && DEBOUNCE_CYCLES > 0 && PTS_W > 0 && CNT_W > 0)
      else $error("mole_hit_detector: zero-valued parameter");
    assert (!press || !btn_level)
      else $error("mole_hit_detector: press without low debounced level");
  end

  assign lamp      = lamp_q;
  assign miss      = miss_q;
  assign hit_valid = (pending_q != '0);
  assign hit_pts   = pending_q;
  assign hit_total = total_q;

endmodule

// File: tb/tb_mole_hit_detector.sv
// Self-checking bench for mole_hit_detector: directed vector table, hand-written
// corner sequences and random button/ready traffic against a reference model.
module tb_mole_hit_detector;

  localparam int DEB     = 4;
  localparam int ON      = 20;
  localparam int OFF     = 10;
  localparam int PTS     = 3;
  localparam int PTS_MAX = (1 << PTS) - 1;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           btn_n = 1'b1;
  logic           hit_ready = 1'b0;
  logic           lamp, hit_valid, miss;
  logic [PTS-1:0] hit_pts;
  logic [15:0]    hit_total;

  int tests = 0;
  int fails = 0;

  mole_hit_detector #(
    .ON_CYCLES(ON), .OFF_CYCLES(OFF), .DEBOUNCE_CYCLES(DEB), .CNT_W(8), .PTS_W(PTS)
  ) dut (
    .clk(clk), .reset(reset), .btn_n(btn_n), .lamp(lamp), .hit_valid(hit_valid),
    .hit_pts(hit_pts), .hit_ready(hit_ready), .miss(miss), .hit_total(hit_total)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic logic [31:0] packOut(logic l, logic m, logic v, logic [2:0] p, logic [15:0] t);
    return {10'd0, l, m, v, p, t};
  endfunction

  // Reference model: elapsed-cycle lamp windows, a button history window and integer points.
  int mHist[$];
  bit mLevel, mPressQ, mLit, mMiss;
  int mElapsed, mPending, mTotal;

  task automatic modelReset();
    mHist = {};
    for (int i = 0; i < DEB + 2; i++) mHist.push_back(1);
    mLevel = 1; mPressQ = 0; mLit = 1; mMiss = 0;
    mElapsed = 0; mPending = 0; mTotal = 0;
  endtask

  task automatic modelStep(input bit b, input bit r);
    bit hit, accept, allDiffer;
    accept = (mPending != 0) && r;
    hit    = mPressQ && mLit;
    mMiss  = 0;
    if (mLit) begin
      if (hit) begin mLit = 0; mElapsed = 0; end
      else if (mElapsed == ON - 1) begin mLit = 0; mElapsed = 0; mMiss = 1; end
      else mElapsed++;
    end else begin
      if (mElapsed == OFF - 1) begin mLit = 1; mElapsed = 0; end
      else mElapsed++;
    end
    if (accept) mPending = hit ? 1 : 0;
    else if (hit && mPending < PTS_MAX) mPending++;
    if (hit) mTotal = (mTotal + 1) % 65536;
    mHist.push_front(int'(b));
    void'(mHist.pop_back());
    allDiffer = 1;
    for (int i = 2; i < DEB + 2; i++) if (mHist[i] == int'(mLevel)) allDiffer = 0;
    mPressQ = 0;
    if (allDiffer) begin
      mPressQ = mLevel;
      mLevel  = !mLevel;
    end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) modelReset();
    else modelStep(btn_n, hit_ready);
  end

  always @(negedge clk) begin
    if (!reset)
      checkOutput("model", packOut(lamp, miss, hit_valid, hit_pts, hit_total),
                  packOut(mLit, mMiss, mPending != 0, 3'(mPending), 16'(mTotal)));
  end

  task automatic applyReset();
    @(negedge clk);
    reset = 1'b1; btn_n = 1'b1; hit_ready = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic waitLamp(input logic v);
    for (int i = 0; i < 200 && lamp !== v; i++) @(negedge clk);
    checkOutput("waitLamp", 32'(lamp), 32'(v));
  endtask

  task automatic doHit();
    waitLamp(1'b0);
    waitLamp(1'b1);
    btn_n = 1'b0;
    repeat (8) @(negedge clk);
    btn_n = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  typedef struct {
    logic        btn;
    logic        rdy;
    int          cycles;
    logic        lamp;
    logic        miss;
    logic        valid;
    logic [2:0]  pts;
    logic [15:0] total;
  } vec_t;

  vec_t vecs[10];

  task automatic applyStimulus();
    for (int i = 0; i < 10; i++) begin
      btn_n = vecs[i].btn;
      hit_ready = vecs[i].rdy;
      repeat (vecs[i].cycles) @(negedge clk);
      checkOutput($sformatf("vec%0d", i), packOut(lamp, miss, hit_valid, hit_pts, hit_total),
                  packOut(vecs[i].lamp, vecs[i].miss, vecs[i].valid, vecs[i].pts, vecs[i].total));
    end
  endtask

  initial begin
    int hold;
    vecs[0] = '{1'b1, 1'b0,  4, 1'b1, 1'b0, 1'b0, 3'd0, 16'd0};
    vecs[1] = '{1'b0, 1'b0,  6, 1'b1, 1'b0, 1'b0, 3'd0, 16'd0};
    vecs[2] = '{1'b0, 1'b0,  1, 1'b0, 1'b0, 1'b1, 3'd1, 16'd1};
    vecs[3] = '{1'b0, 1'b1,  1, 1'b0, 1'b0, 1'b0, 3'd0, 16'd1};
    vecs[4] = '{1'b0, 1'b0,  2, 1'b0, 1'b0, 1'b0, 3'd0, 16'd1};
    vecs[5] = '{1'b1, 1'b0,  6, 1'b0, 1'b0, 1'b0, 3'd0, 16'd1};
    vecs[6] = '{1'b1, 1'b0,  1, 1'b1, 1'b0, 1'b0, 3'd0, 16'd1};
    vecs[7] = '{1'b1, 1'b0, 19, 1'b1, 1'b0, 1'b0, 3'd0, 16'd1};
    vecs[8] = '{1'b1, 1'b0,  1, 1'b0, 1'b1, 1'b0, 3'd0, 16'd1};
    vecs[9] = '{1'b1, 1'b0,  1, 1'b0, 1'b0, 1'b0, 3'd0, 16'd1};

    // Idle lamp cadence: 20 lit, miss on the first dark cycle, 10 dark.
    applyReset();
    for (int k = 0; k < 66; k++) begin
      if (k > 0) @(negedge clk);
      checkOutput($sformatf("idle lamp k=%0d", k), 32'(lamp), 32'((k % 30) < 20));
      checkOutput($sformatf("idle miss k=%0d", k), 32'(miss), 32'(k % 30 == 20));
    end
    checkOutput("idle valid", 32'(hit_valid), 32'd0);

    applyReset();
    applyStimulus();

    // Bounce shorter than the debounce window.
    applyReset();
    for (int i = 0; i < 12; i++) begin
      btn_n = ((i / 2) % 2) != 0;
      @(negedge clk);
    end
    btn_n = 1'b1;
    repeat (7) @(negedge clk);
    checkOutput("bounce lamp k19", 32'(lamp), 32'd1);
    @(negedge clk);
    checkOutput("bounce k20", packOut(lamp, miss, hit_valid, hit_pts, hit_total),
                packOut(1'b0, 1'b1, 1'b0, 3'd0, 16'd0));

    // Press landing in the dark window is ignored.
    applyReset();
    repeat (20) @(negedge clk);
    btn_n = 1'b0;
    repeat (6) @(negedge clk);
    btn_n = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("dark press k29", packOut(lamp, miss, hit_valid, hit_pts, hit_total),
                packOut(1'b0, 1'b0, 1'b0, 3'd0, 16'd0));
    @(negedge clk);
    checkOutput("dark press k30 lamp", 32'(lamp), 32'd1);

    // Saturation at 7 with hit_total still counting.
    applyReset();
    for (int i = 0; i < 9; i++) doHit();
    checkOutput("sat pts", 32'(hit_pts), 32'd7);
    checkOutput("sat total", 32'(hit_total), 32'd9);
    checkOutput("sat valid", 32'(hit_valid), 32'd1);
    hit_ready = 1'b1;
    @(negedge clk);
    hit_ready = 1'b0;
    checkOutput("sat drain", packOut(1'b0, 1'b0, hit_valid, hit_pts, 16'd0),
                packOut(1'b0, 1'b0, 1'b0, 3'd0, 16'd0));

    // Accept coinciding with a hit, then reset with points pending.
    applyReset();
    for (int i = 0; i < 3; i++) doHit();
    checkOutput("pre-accept pts", 32'(hit_pts), 32'd3);
    waitLamp(1'b0);
    waitLamp(1'b1);
    btn_n = 1'b0;
    repeat (6) @(negedge clk);
    hit_ready = 1'b1;
    @(negedge clk);
    hit_ready = 1'b0;
    checkOutput("accept+hit pts", 32'(hit_pts), 32'd1);
    checkOutput("accept+hit total", 32'(hit_total), 32'd4);
    btn_n = 1'b1;
    repeat (8) @(negedge clk);
    doHit();
    waitLamp(1'b1);
    repeat (3) @(negedge clk);
    checkOutput("pre-reset pts", 32'(hit_pts), 32'd2);
    reset = 1'b1;
    #1;
    checkOutput("midreset", packOut(lamp, miss, hit_valid, hit_pts, hit_total),
                packOut(1'b1, 1'b0, 1'b0, 3'd0, 16'd0));
    @(negedge clk);
    reset = 1'b0;

    // Random button and ready traffic, checked by the model every cycle.
    applyReset();
    hold = 0;
    for (int c = 0; c < 1500; c++) begin
      if (hold == 0) begin
        btn_n = 1'($urandom_range(0, 1));
        hold  = int'($urandom_range(1, 12));
      end
      hold--;
      hit_ready = ($urandom_range(0, 3) == 0);
      @(negedge clk);
    end
    hit_ready = 1'b0;
    btn_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mole_hit_detector.md
Name: mole_hit_detector

Overview:
- Front-end stage of the whack-a-mole game. It conditions the raw active-low push button and runs the mole-lamp on/off timing.
- It qualifies a press as a hit only while the lamp is lit, and accumulates hit points.
- Points are offered through a valid/ready handshake to the score-write injector, which places them into register 30 of the register file when the CPU write port is idle.

Parameters:
- ON_CYCLES, 100000000, lamp-lit window in clk cycles (1 s at 100 MHz).
- OFF_CYCLES, 50000000, lamp-dark window in clk cycles.
- DEBOUNCE_CYCLES, 1000000, consecutive stable samples required to accept a new button level.
- CNT_W, 27, width of the lamp timer and the debounce counter; must hold max(ON_CYCLES, OFF_CYCLES, DEBOUNCE_CYCLES).
- PTS_W, 3, width of the pending-points accumulator and hit_pts.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- btn_n  input  1  raw push button, active low, asynchronous to clk.
- lamp  output  1  mole LED; 1 = lit.
- hit_valid  output  1  pending points available (pending != 0).
- hit_pts  output  PTS_W  pending point count; stable while hit_valid && !hit_ready.
- hit_ready  input  1  consumer accepts hit_pts this cycle.
- miss  output  1  one-cycle pulse when the lit window expires without a hit.
- hit_total  output  16  free-running count of accepted hits; wraps at 65535 -> 0.

Behaviour:
- Reset (async assert, sync release):
  - lamp = 1, state = LIT, timer = 0.
  - sync FFs = 1, debounced level = 1, debounce counter = 0.
  - pending = 0, hit_valid = 0, hit_pts = 0, miss = 0, hit_total = 0.
- Input conditioning:
  - Two-flop synchronizer on btn_n.
  - Debounce: while the synced level differs from the debounced level, the counter increments; equality clears it.
  - When the counter reaches DEBOUNCE_CYCLES-1 with the level still differing, the debounced level flips and the counter clears.
  - press = one-cycle pulse on a 1 -> 0 transition of the debounced level.
  - Total latency from a btn_n edge to press is DEBOUNCE_CYCLES+2 cycles. Releases produce no pulse.
- Lamp FSM, states LIT and DARK:
  - LIT:
    - If press: next = DARK, timer = 0, hit event. Press takes priority over a simultaneous timeout.
    - Else if timer == ON_CYCLES-1: next = DARK, timer = 0, miss = 1 for one cycle.
    - Else timer += 1.
  - DARK:
    - Presses are ignored (no hit, no penalty).
    - If timer == OFF_CYCLES-1: next = LIT, timer = 0. Else timer += 1.
  - lamp is a registered output equal to (state == LIT).
- Points accumulator:
  - On a hit event, pending increments, saturating at 2^PTS_W-1. Points beyond saturation are dropped; hit_total still counts.
  - hit_valid = (pending != 0); hit_pts = pending. Both are combinational from the pending register.
  - Handshake: when hit_valid && hit_ready, pending clears to 0.
  - Simultaneous accept and hit event: pending becomes 1, so no point is lost.
  - hit_ready while hit_valid = 0 has no effect.
  - hit_total increments by 1 on every hit event, independent of saturation.
- Mid-operation reset: all state returns to reset values immediately. Pending points are discarded and no partial handshake completes.
- Widths: timer comparisons use CNT_W unsigned. Parameters with value 0 are illegal and are checked with a simulation-time assertion.

Decomposition:
- Shared package (game_pkg):
  - lamp-state encoding (LIT = 1'b0, DARK = 1'b1).
  - Default timing constants ON_CYCLES, OFF_CYCLES, DEBOUNCE_CYCLES.
  - PTS_W, register index SCORE_REG = 5'd30.
- One sub-module: btn_debounce. It contains the synchronizer, debounce counter and falling-edge pulse, with parameter DEBOUNCE_CYCLES and ports clk, reset, btn_n, level, press.
- The FSM and accumulator stay in mole_hit_detector.

Test Plan (bench parameters DEBOUNCE_CYCLES=4, ON_CYCLES=20, OFF_CYCLES=10, PTS_W=3):
1. Reset, btn_n held 1 -> lamp=1 for exactly 20 cycles, then miss pulses once. lamp=0 for 10 cycles, then lamp=1. The pattern repeats with hit_valid=0 throughout.
2. btn_n low at cycle 5 of LIT, held 10 cycles -> press 6 cycles later, lamp=0 next cycle, hit_valid=1, hit_pts=1. With hit_ready=1 one cycle later: hit_valid=0, hit_total=1.
3. Bounce: btn_n toggles every 2 cycles for 12 cycles, then stays 1 -> no press, no hit, lamp timing unaffected.
4. Press during DARK -> no hit, hit_total unchanged, lamp returns to 1 after the full 10-cycle window.
5. hit_ready=0 held; 9 hits across lit windows -> hit_pts saturates at 7, hit_total=9. Raise hit_ready for one cycle -> hit_pts=0.
6. Hit event in the same cycle as an accept with pending=3 -> pending=1 next cycle, hit_pts=1. Assert reset mid-LIT with pending=2 -> lamp=1, hit_valid=0, hit_total=0 immediately.
